mips_cpu_data_memory_ws: RTL
============================

// Module: mips_cpu_data_memory_ws
// PURPOSE
//  Parametrised data memory for the Harvard MIPS CPU, next generation of the fixed data memory.
//  Sits on the CPU data port (data_address/data_read/data_write) and adds configurable wait states
//  (waitrequest stall handshake) and sub-word access decode for LB/LBU/LH/LHU/LW and SB/SH/SW.
//  Little-endian byte lanes; word-indexed storage at (data_address-BASE_ADDR)>>2.
// PARAMETERS
//  DEPTH_WORDS  1024          number of 32-bit words stored
//  BASE_ADDR    32'h00000000  byte address of word 0
//  WAIT_STATES  0             stall cycles per access, 0..15
//  WP_LO_WORD   0             first write-protected word index (used only with WRITE_PROTECT_EN)
//  WP_HI_WORD   0             last write-protected word index, inclusive (WRITE_PROTECT_EN only)
// PORTS
//  clk             in   1   rising-edge clock
//  reset           in   1   asynchronous, active-low reset
//  clk_enable      in   1   0 = freeze FSM/counter, no writes, no new accepts
//  data_address    in   32  byte address
//  data_read       in   1   read request, held until waitrequest=0
//  data_write      in   1   write request, held until waitrequest=0
//  access_mode     in   3   0=W 1=HU 2=H 3=BU 4=B; 5..7 illegal (stores ignore sign)
//  data_writedata  in   32  store data, right-justified (byte in [7:0], half in [15:0])
//  data_readdata   out  32  load result, extended per access_mode; 0 when not completing
//  waitrequest     out  1   1 = access not yet complete, master must hold all inputs
//  addr_error      out  1   1-cycle pulse on the completing cycle of a rejected access
// BEHAVIOUR
//  - Reset (reset=0): state IDLE, cnt=0, waitrequest=0, addr_error=0, data_readdata=0; array
//    contents NOT cleared. Reset mid-WAIT aborts the access; pending write is discarded.
//  - FSM IDLE/WAIT. req = clk_enable & (data_read|data_write).
//    IDLE: req & WAIT_STATES==0 -> complete this cycle (stay IDLE);
//          req & WAIT_STATES>0  -> waitrequest=1, cnt<=WAIT_STATES-1, latch addr/mode/op, go WAIT.
//    WAIT: cnt!=0 -> waitrequest=1, cnt<=cnt-1; cnt==0 -> waitrequest=0, complete, go IDLE.
//  - waitrequest is combinational from state/cnt/req; total latency = WAIT_STATES+1 cycles from
//    request assertion to completing cycle; back-to-back accepts allowed the cycle after completion.
//  - Completion: read -> data_readdata valid combinationally in that cycle; write -> byte lanes
//    committed on that rising edge. Writes never affect the read of the same cycle.
//  - Lanes: W all 4; H/HU lane pair addr[1]; B/BU lane addr[1:0]. H/B sign-extend, HU/BU zero-extend.
//  - Error (addr_error=1, no write, data_readdata=0): W with addr[1:0]!=0; H/HU with addr[0]=1;
//    mode 5..7; addr<BASE_ADDR or (addr-BASE_ADDR)>=4*DEPTH_WORDS; data_read&data_write both set.
//    Error still observes full WAIT_STATES latency.
//  - clk_enable=0 in WAIT: cnt held, waitrequest held 1, no completion until re-enabled.
//  - Inputs changing while waitrequest=1: protocol violation; block uses latched copies.
// CONFIGURATION
//  WRITE_PROTECT_EN defined: writes to word index WP_LO_WORD..WP_HI_WORD are dropped and
//    raise addr_error on completion; reads of that range are unaffected.
//  WRITE_PROTECT_EN undefined: WP_* ignored; whole array writable; no extra logic.
// TESTING
//  1 WAIT_STATES=0: SW 0x8000_ABCD @0x8, LHU @0x8 -> readdata 0x0000ABCD same cycle, waitrequest 0.
//  2 Same word: LH @0xA -> 0xFFFF8000; LB @0x9 -> 0xFFFFFFAB; LBU @0x9 -> 0x000000AB.
//  3 WAIT_STATES=3: LW @0x0 -> waitrequest 1 for 3 cycles, data on 4th; clk_enable low 2 cycles
//    mid-WAIT -> completion delayed exactly 2 cycles.
//  4 LW @0x2, LH @0x1, mode 6, read+write together, addr 4*DEPTH_WORDS -> addr_error 1-cycle pulse,
//    readdata 0, memory unchanged (read back original).
//  5 WAIT_STATES=2: SB 0x55 @0x4, assert reset during WAIT -> outputs 0 immediately, word @0x4
//    unchanged after reset release.
//  6 WRITE_PROTECT_EN, WP_LO_WORD=WP_HI_WORD=2: SW 0x1234 @0x8 -> addr_error, LW @0x8 returns
//    old value; SW @0xC succeeds with no error.

Source files
------------

// File: rtl/mips_cpu_data_memory_ws_if.sv
// CPU data-port bus between the MIPS core (master) and the wait-state data memory (slave).
interface mips_cpu_data_memory_ws_if;
    logic [31:0] data_address;
    logic        data_read;
    logic        data_write;
    logic [2:0]  access_mode;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;
    logic        waitrequest;
    logic        addr_error;

    modport master (
        output data_address, data_read, data_write, access_mode, data_writedata,
        input  data_readdata, waitrequest, addr_error
    );

    modport slave (
        input  data_address, data_read, data_write, access_mode, data_writedata,
        output data_readdata, waitrequest, addr_error
    );
endinterface

// File: rtl/mips_cpu_data_memory_ws.sv
// Harvard MIPS data memory with configurable wait states and LB/LBU/LH/LHU/LW/SB/SH/SW lane decode.
// Optional write protection of a word range is enabled by defining WRITE_PROTECT_EN.
module mips_cpu_data_memory_ws #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned WP_LO_WORD  = 0,
    parameter int unsigned WP_HI_WORD  = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clk_enable,
    mips_cpu_data_memory_ws_if.slave    bus
);
    localparam int          AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [33:0] LIMIT    = 34'(DEPTH_WORDS) * 34'd4;
    localparam logic [3:0]  CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
`ifdef WRITE_PROTECT_EN
    localparam bit          WP_EN    = 1'b1;
`else
    localparam bit          WP_EN    = 1'b0;
`endif

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic [31:0] r_addr, r_wdata;
    logic [2:0]  r_mode;
    logic        r_rd, r_wr;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic        w_req, w_wait, w_done, w_fire, w_in_wait;
    logic [31:0] w_addr, w_wdata, w_off, w_word;
    logic [2:0]  w_mode;
    logic        w_rd, w_wr;
    logic        w_align_err, w_range_err, w_wp, w_err;
    logic [AW-1:0] w_idx;
    logic [3:0]  w_be;
    logic [31:0] w_wlanes;

    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] a,
                                                 input logic [2:0] mode);
        logic [15:0] h;
        logic [7:0]  b;
        h = a[1] ? word[31:16] : word[15:0];
        b = 8'(word >> {a, 3'b000});
        case (mode)
            3'd1:    return {16'h0000, h};
            3'd2:    return {{16{h[15]}}, h};
            3'd3:    return {24'h000000, b};
            3'd4:    return {{24{b[7]}}, b};
            default: return word;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [1:0] a, input logic [2:0] mode);
        case (mode)
            3'd1, 3'd2: return a[1] ? 4'b1100 : 4'b0011;
            3'd3, 3'd4: return 4'b0001 << a;
            default:    return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [31:0] wd, input logic [2:0] mode);
        case (mode)
            3'd1, 3'd2: return {2{wd[15:0]}};
            3'd3, 3'd4: return {4{wd[7:0]}};
            default:    return wd;
        endcase
    endfunction

    assign w_req = clk_enable & (bus.data_read | bus.data_write);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_wait      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (WAIT_STATES == 0) begin
                        w_done = 1'b1;
                    end else begin
                        w_wait      = 1'b1;
                        w_cnt_nxt   = CNT_LOAD;
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!clk_enable) begin
                    w_wait = 1'b1;
                end else if (r_cnt != 4'd0) begin
                    w_wait    = 1'b1;
                    w_cnt_nxt = r_cnt - 4'd1;
                end else begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Capture the request on accept; the master is not trusted to hold its inputs during WAIT.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && w_req) begin
            r_addr  <= bus.data_address;
            r_wdata <= bus.data_writedata;
            r_mode  <= bus.access_mode;
            r_rd    <= bus.data_read;
            r_wr    <= bus.data_write;
        end
    end

    assign w_in_wait = (r_state == S_WAIT);
    assign w_addr    = w_in_wait ? r_addr  : bus.data_address;
    assign w_wdata   = w_in_wait ? r_wdata : bus.data_writedata;
    assign w_mode    = w_in_wait ? r_mode  : bus.access_mode;
    assign w_rd      = w_in_wait ? r_rd    : bus.data_read;
    assign w_wr      = w_in_wait ? r_wr    : bus.data_write;

    assign w_off       = w_addr - BASE_ADDR;
    assign w_range_err = (w_addr < BASE_ADDR) || ({2'b00, w_off} >= LIMIT);

    always_comb begin
        w_align_err = 1'b0;
        case (w_mode)
            3'd0:       w_align_err = (w_addr[1:0] != 2'b00);
            3'd1, 3'd2: w_align_err = w_addr[0];
            3'd3, 3'd4: w_align_err = 1'b0;
            default:    w_align_err = 1'b1;
        endcase
    end

    // With WP_EN a constant 0 this term folds away entirely.
    assign w_wp  = WP_EN && w_wr && (w_off[31:2] >= 30'(WP_LO_WORD)) && (w_off[31:2] <= 30'(WP_HI_WORD));
    assign w_err = w_align_err | w_range_err | (w_rd & w_wr) | w_wp;

    assign w_fire   = w_done & reset;
    assign w_idx    = w_off[AW+1:2];
    assign w_word   = r_mem[w_idx];
    assign w_be     = store_be(w_addr[1:0], w_mode);
    assign w_wlanes = store_lanes(w_wdata, w_mode);

    always_ff @(posedge clk) begin
        if (w_fire && w_wr && !w_err) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wlanes[8*i +: 8];
            end
        end
    end

    assign bus.waitrequest   = w_wait & reset;
    assign bus.addr_error    = w_fire & w_err;
    assign bus.data_readdata = (w_fire && w_rd && !w_err) ? load_extract(w_word, w_addr[1:0], w_mode)
                                                          : 32'h0000_0000;
endmodule
